// File: rtl/parking_pkg.sv
// Shared key codes, entry state encoding and digit width for the parking
// keypad front end.
package parking_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_BKSP  = 4'hB;
  localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    PRESENT = 2'd3
  } entry_state_t;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/parking_entry_timer.sv
// Inactivity timer: counts cycles while run is high, restarts on clear, and
// flags expire on the last cycle of the window when no clear is present.
module parking_entry_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_q;

  assign expire = run && !clear && (count_q == LAST);

  // Outside the collecting states the counter sits frozen at zero.
  always_ff @(posedge clk) begin
    if (!reset_n || clear || !run || expire)
      count_q <= '0;
    else
      count_q <= count_q + TMR_W'(1);
  end

endmodule

// File: rtl/parking_keypad_entry.sv
// Keypad collector ahead of the parking controller: buffers password digits,
// handles clear/backspace/enter, and hands the code over with valid/ack.
module parking_keypad_entry
  import parking_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         car_present,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  input  logic                         pw_ack,
  output logic [4*DIGITS-1:0]          pw_code,
  output logic                         pw_valid,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         busy,
  output logic                         key_err,
  output logic                         timeout
);

  localparam int BUF_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  entry_state_t     state_q, state_n;
  logic [BUF_W-1:0] buffer_q, buffer_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [BUF_W-1:0] pw_code_q, pw_code_n;
  logic             pw_valid_q, pw_valid_n;
  logic             busy_q;
  logic             key_err_q, key_err_n;
  logic             timeout_q, timeout_n;
  logic             timer_run;
  logic             timer_expire;

  assign timer_run = (state_q == COLLECT) || (state_q == FULL);

  parking_entry_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (key_valid),
    .run     (timer_run),
    .expire  (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      buffer_q   <= '0;
      count_q    <= '0;
      pw_code_q  <= '0;
      pw_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      key_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      buffer_q   <= buffer_n;
      count_q    <= count_n;
      pw_code_q  <= pw_code_n;
      pw_valid_q <= pw_valid_n;
      busy_q     <= (state_n != IDLE);
      key_err_q  <= key_err_n;
      timeout_q  <= timeout_n;
    end
  end

  // Priority while collecting: car leaving, then a key, then the timer.
  always_comb begin
    state_n    = state_q;
    buffer_n   = buffer_q;
    count_n    = count_q;
    pw_code_n  = pw_code_q;
    pw_valid_n = pw_valid_q;
    key_err_n  = 1'b0;
    timeout_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (car_present)
          state_n = COLLECT;
      end

      COLLECT, FULL: begin
        if (!car_present) begin
          buffer_n = '0;
          count_n  = '0;
          state_n  = IDLE;
        end else if (key_valid) begin
          if (is_digit(key_code)) begin
            if (state_q == COLLECT) begin
              buffer_n = (buffer_q << DIGIT_W) | BUF_W'(key_code);
              count_n  = count_q + CNT_W'(1);
              if (count_q == CNT_W'(DIGITS - 1))
                state_n = FULL;
            end else begin
              key_err_n = 1'b1;
            end
          end else if (key_code == KEY_BKSP) begin
            if (count_q != '0) begin
              buffer_n = buffer_q >> DIGIT_W;
              count_n  = count_q - CNT_W'(1);
              state_n  = COLLECT;
            end
          end else if (key_code == KEY_CLEAR) begin
            buffer_n = '0;
            count_n  = '0;
            state_n  = COLLECT;
          end else if (key_code == KEY_ENTER && state_q == FULL) begin
            pw_code_n  = buffer_q;
            pw_valid_n = 1'b1;
            state_n    = PRESENT;
          end else begin
            key_err_n = 1'b1;
          end
        end else if (timer_expire) begin
          timeout_n = 1'b1;
          buffer_n  = '0;
          count_n   = '0;
          state_n   = IDLE;
        end
      end

      PRESENT: begin
        if (pw_ack && pw_valid_q) begin
          pw_valid_n = 1'b0;
          pw_code_n  = '0;
          buffer_n   = '0;
          count_n    = '0;
          state_n    = IDLE;
        end
      end

      default: begin
        buffer_n   = '0;
        count_n    = '0;
        pw_code_n  = '0;
        pw_valid_n = 1'b0;
        state_n    = IDLE;
      end
    endcase
  end

  assign pw_code     = pw_code_q;
  assign pw_valid    = pw_valid_q;
  assign digit_count = count_q;
  assign busy        = busy_q;
  assign key_err     = key_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_parking_keypad_entry.sv
// Self-checking bench: directed vector table, hand-written timeout sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_parking_keypad_entry;

  localparam int DIGITS         = 2;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int TMR_W          = 16;
  localparam int CNT_W          = $clog2(DIGITS + 1);
  localparam int PW_W           = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             car_present = 1'b0;
  logic             key_valid = 1'b0;
  logic [3:0]       key_code = 4'h0;
  logic             pw_ack = 1'b0;
  logic [PW_W-1:0]  pw_code;
  logic             pw_valid;
  logic [CNT_W-1:0] digit_count;
  logic             busy;
  logic             key_err;
  logic             timeout;

  always #5 clk = ~clk;

  parking_keypad_entry #(
    .DIGITS         (DIGITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .car_present (car_present),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .pw_ack      (pw_ack),
    .pw_code     (pw_code),
    .pw_valid    (pw_valid),
    .digit_count (digit_count),
    .busy        (busy),
    .key_err     (key_err),
    .timeout     (timeout)
  );

  typedef struct {
    logic            rst_n;
    logic            car;
    logic            kv;
    logic [3:0]      kc;
    logic            ack;
    logic [PW_W-1:0] pw;
    logic            pwv;
    int              cnt;
    logic            bsy;
    logic            err;
    logic            to;
  } vec_t;

  int checks = 0;
  int passed = 0;
  int cycle  = 0;

  // Reference model: entry is a list of typed digits plus two phase flags.
  bit              m_active  = 0;
  bit              m_present = 0;
  int              m_digits[$];
  int              m_idle    = 0;
  logic [PW_W-1:0] m_pw      = '0;
  bit              m_pwv     = 0;
  bit              m_err     = 0;
  bit              m_to      = 0;

  function automatic vec_t mk(logic rst_n, logic car, logic kv, logic [3:0] kc, logic ack,
                              logic [PW_W-1:0] pw, logic pwv, int cnt, logic bsy,
                              logic err, logic to);
    vec_t v;
    v.rst_n = rst_n; v.car = car; v.kv = kv; v.kc = kc; v.ack = ack;
    v.pw = pw; v.pwv = pwv; v.cnt = cnt; v.bsy = bsy; v.err = err; v.to = to;
    return v;
  endfunction

  function automatic logic [PW_W-1:0] model_pack();
    logic [31:0] p = 0;
    foreach (m_digits[i]) p = p * 16 + m_digits[i];
    return p[PW_W-1:0];
  endfunction

  task automatic model_step();
    m_err = 0;
    m_to  = 0;
    if (!reset_n) begin
      m_active = 0; m_present = 0; m_digits.delete(); m_idle = 0; m_pw = '0; m_pwv = 0;
    end else if (m_present) begin
      if (pw_ack) begin
        m_present = 0; m_pwv = 0; m_pw = '0; m_digits.delete();
      end
    end else if (!m_active) begin
      if (car_present) begin
        m_active = 1; m_idle = 0;
      end
    end else if (!car_present) begin
      m_active = 0; m_digits.delete(); m_idle = 0;
    end else if (key_valid) begin
      m_idle = 0;
      if (key_code <= 4'd9) begin
        if (m_digits.size() < DIGITS) m_digits.push_back(int'(key_code));
        else m_err = 1;
      end else if (key_code == 4'hA) begin
        m_digits.delete();
      end else if (key_code == 4'hB) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back());
      end else if (key_code == 4'hC) begin
        if (m_digits.size() == DIGITS) begin
          m_pw = model_pack(); m_pwv = 1; m_present = 1; m_active = 0;
        end else begin
          m_err = 1;
        end
      end else begin
        m_err = 1;
      end
    end else if (m_idle == TIMEOUT_CYCLES - 1) begin
      m_to = 1; m_active = 0; m_digits.delete(); m_idle = 0;
    end else begin
      m_idle++;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, actual, expected);
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic car, input logic kv,
                                input logic [3:0] kc, input logic ack);
    reset_n     = rst_n;
    car_present = car;
    key_valid   = kv;
    key_code    = kc;
    pw_ack      = ack;
    @(posedge clk);
    model_step();
    #1;
    cycle++;
  endtask

  task automatic check_vec(input vec_t v);
    check_output("pw_code",     32'(pw_code),     32'(v.pw));
    check_output("pw_valid",    32'(pw_valid),    32'(v.pwv));
    check_output("digit_count", 32'(digit_count), v.cnt);
    check_output("busy",        32'(busy),        32'(v.bsy));
    check_output("key_err",     32'(key_err),     32'(v.err));
    check_output("timeout",     32'(timeout),     32'(v.to));
  endtask

  task automatic run_vec(input vec_t v);
    apply_stimulus(v.rst_n, v.car, v.kv, v.kc, v.ack);
    check_vec(v);
  endtask

  task automatic check_model();
    check_output("model pw_code",     32'(pw_code),     32'(m_pw));
    check_output("model pw_valid",    32'(pw_valid),    32'(m_pwv));
    check_output("model digit_count", 32'(digit_count), m_digits.size());
    check_output("model busy",        32'(busy),        32'(m_active || m_present));
    check_output("model key_err",     32'(key_err),     32'(m_err));
    check_output("model timeout",     32'(timeout),     32'(m_to));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[$];

    //             rst car kv  kc    ack  pw     pwv cnt bsy err to
    tbl.push_back(mk(0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h2, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h6, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hC, 0, 8'h26, 1, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h2, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h7, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hB, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h6, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hC, 0, 8'h26, 1, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h5, 0, 8'h26, 1, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 8'h26, 1, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h5, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hC, 0, 8'h00, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'hA, 0, 8'h00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h1, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h4, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h9, 0, 8'h00, 0, 2, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'hC, 0, 8'h14, 1, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 4'h7, 1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h4, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 4'h8, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hB, 0, 8'h00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hE, 0, 8'h00, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'h1, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h2, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hB, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hF, 0, 8'h00, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'h3, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hA, 0, 8'h00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h9, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'h8, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hC, 0, 8'h98, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));

    $display("[TB] directed vector table: %0d rows", tbl.size());
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    $display("[TB] inactivity timeout sequence");
    run_vec(mk(0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0));
    run_vec(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 0));
    run_vec(mk(1, 1, 1, 4'h3, 0, 8'h00, 0, 1, 1, 0, 0));
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
      apply_stimulus(1, 1, 0, 4'h0, 0);
      check_output("timeout early", 32'(timeout), 0);
    end
    run_vec(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 1));
    run_vec(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 0));
    run_vec(mk(1, 1, 1, 4'hE, 0, 8'h00, 0, 0, 1, 1, 0));

    $display("[TB] key on the expiry cycle beats the timeout");
    run_vec(mk(1, 1, 1, 4'h3, 0, 8'h00, 0, 1, 1, 0, 0));
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
      apply_stimulus(1, 1, 0, 4'h0, 0);
      check_output("timeout early", 32'(timeout), 0);
    end
    run_vec(mk(1, 1, 1, 4'h5, 0, 8'h00, 0, 2, 1, 0, 0));
    run_vec(mk(1, 1, 0, 4'h0, 0, 8'h00, 0, 2, 1, 0, 0));

    $display("[TB] randomized traffic against reference model");
    apply_stimulus(0, 0, 0, 4'h0, 0);
    check_model();
    for (int i = 0; i < 3000; i++) begin
      logic       r_rst, r_car, r_kv, r_ack;
      logic [3:0] r_kc;
      r_rst = ($urandom_range(0, 499) != 0);
      r_car = ($urandom_range(0, 19) != 0);
      r_kv  = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 3) == 0) r_kc = 4'(4'hA + $urandom_range(0, 5));
      else r_kc = 4'($urandom_range(0, 9));
      r_ack = ($urandom_range(0, 3) == 0);
      apply_stimulus(r_rst, r_car, r_kv, r_kc, r_ack);
      check_model();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/parking_keypad_entry.md
Name: parking_keypad_entry

Overview:
- Front-end keypad collector that sits ahead of parking_system.
- Gathers password digits typed by the driver at the entrance, supports backspace, clear and enter, and presents the assembled code to the parking controller with a valid/ack handshake.
- Enforces an inactivity timeout and abandons the entry when the car leaves the entrance sensor.

Parameters:
- DIGITS, 2, number of 4-bit digits in a password.
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT/FULL before the entry is discarded.
- TMR_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- car_present  input  1  entrance sensor level (same signal as sensor_entrance).
- key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
- key_code  input  4  0x0-0x9 digit, 0xA clear, 0xB backspace, 0xC enter, 0xD-0xF illegal.
- pw_ack  input  1  parking controller has consumed pw_code.
- pw_code  output  4*DIGITS  assembled code; first digit in MS nibble (password_1 = [7:4], password_2 = [3:0] at default).
- pw_valid  output  1  pw_code is presented; held until acked.
- digit_count  output  $clog2(DIGITS+1)  digits currently buffered.
- busy  output  1  state != IDLE.
- key_err  output  1  one-cycle pulse on a rejected key.
- timeout  output  1  one-cycle pulse when an entry is discarded by timer.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - State goes to IDLE.
  - Buffer, digit_count, pw_code and timer are 0.
  - pw_valid, key_err and timeout are 0; busy is 0.
  - Reset mid-entry or mid-handshake discards everything.
- All outputs are registered. A key is accepted at the edge where key_valid=1, and its effects are visible the following cycle.
- IDLE:
  - Keys are ignored; no key_err.
  - car_present=1 moves to COLLECT next edge.
- COLLECT (digit_count < DIGITS):
  - Digit: buffer = (buffer<<4)|key_code, count+1. Reaching DIGITS moves to FULL.
  - Backspace: if count>0, buffer>>=4 (zero fill) and count-1; at count=0 it is a no-op with no error.
  - Clear: buffer=0, count=0.
  - Enter: rejected with key_err.
  - Illegal code: rejected with key_err.
- FULL (count = DIGITS):
  - Digit: rejected with key_err, buffer unchanged.
  - Backspace: as in COLLECT, back to COLLECT with count = DIGITS-1.
  - Clear: count 0, back to COLLECT.
  - Enter: pw_code <= buffer and pw_valid <= 1, state goes to PRESENT.
  - Illegal code: rejected with key_err.
- PRESENT:
  - pw_code is stable and pw_valid is held high.
  - Keys are ignored with no key_err; the timer is frozen at 0; car_present is not checked.
  - pw_ack=1 (while pw_valid=1): pw_valid=0, buffer/count/pw_code cleared, go to IDLE next edge.
  - pw_ack while not in PRESENT is ignored.
- Abandon:
  - In COLLECT/FULL, car_present=0 clears buffer and count and goes to IDLE. This has priority over a key in the same cycle.
  - No timeout pulse is generated for an abandon.
- Timer:
  - Counts cycles in COLLECT/FULL and resets to 0 on every key_valid.
  - When the counter is at TIMEOUT_CYCLES-1 with no key this cycle: timeout pulses, buffer/count are cleared, and the state goes to IDLE.
  - A key in the same cycle wins over the timeout.
  - Re-entry to COLLECT from IDLE takes one cycle when car_present is still 1.
- State encoding: IDLE, COLLECT, FULL, PRESENT; all unused encodings recover to IDLE.

Decomposition:
- parking_pkg holds:
  - key code constants KEY_CLEAR=4'hA, KEY_BKSP=4'hB, KEY_ENTER=4'hC;
  - the state enum;
  - the DIGIT_W=4 constant.
- One sub-module, parking_entry_timer:
  - inputs: clear, run;
  - output: expire;
  - parameters: TIMEOUT_CYCLES, TMR_W.

Test Plan:
- Reset, car_present=1, keys 2, 6, ENTER -> pw_code=8'h26 and pw_valid=1 the cycle after ENTER; pw_ack -> pw_valid=0 next cycle, digit_count=0, busy=0.
- Keys 2, 7, BKSP, 6, ENTER -> pw_code=8'h26; the count sequence is 1, 2, 1, 2.
- Keys 5, ENTER -> key_err single pulse, stays in COLLECT; then 1, 4, 9 -> 9 rejected with key_err, then ENTER gives pw_code=8'h14.
- Key 3, then no keys for 1000 cycles -> timeout pulses once, digit_count=0, busy low; key 0xE alone -> key_err with no state change.
- Key 4 with car_present dropping in the same cycle as key 8 -> 8 is discarded, state IDLE, no timeout; raise car_present -> COLLECT after 1 cycle.
- reset_n=0 during PRESENT with pw_valid=1 -> all outputs 0 after that edge; pw_ack later is ignored.
